// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: branch-class opcodes and the branch-resolve FSM encoding.
package simplerisc_pkg;

  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch decision: opcode plus last-CMP flags -> taken, and whether
// the target comes from ra (ret) rather than the PC-relative target.
module branch_cond
  import simplerisc_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic       gt_flag,
  input  logic       eq_flag,
  output logic       taken,
  output logic       use_ra
);

  always_comb begin
    taken  = 1'b0;
    use_ra = 1'b0;
    case (opcode)
      OP_BEQ:        taken = eq_flag;
      OP_BGT:        taken = gt_flag;
      OP_B, OP_CALL: taken = 1'b1;
      OP_RET: begin
        taken  = 1'b1;
        use_ra = 1'b1;
      end
      default: begin
        taken  = 1'b0;
        use_ra = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: registered one-cycle redirect, IF/OF squash sequence
// that freezes under stall, and a saturating taken-branch counter.
module branch_resolve
  import simplerisc_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [4:0]        ex_opcode,
  input  logic [DATA_W-1:0] ex_branch_target,
  input  logic [DATA_W-1:0] ex_ra_val,
  input  logic              GT_flag,
  input  logic              EQ_flag,
  input  logic              stall,
  output logic              isBranchTaken,
  output logic [DATA_W-1:0] branch_pc,
  output logic              flush_if,
  output logic              flush_of,
  output logic              busy,
  output logic [CNT_W-1:0]  taken_count
);

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       taken;
  logic       use_ra;
  logic       resolve;

  branch_cond u_cond (
    .opcode  (ex_opcode),
    .gt_flag (GT_flag),
    .eq_flag (EQ_flag),
    .taken   (taken),
    .use_ra  (use_ra)
  );

  // Instructions seen in EX while flushing are wrong-path and must never resolve.
  assign resolve = (state == ST_IDLE) && ex_valid && !stall && taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= 3'd0;
      isBranchTaken <= 1'b0;
      branch_pc     <= '0;
      flush_if      <= 1'b0;
      flush_of      <= 1'b0;
      busy          <= 1'b0;
      taken_count   <= '0;
    end else begin
      isBranchTaken <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (resolve) begin
            state         <= ST_FLUSH;
            cnt           <= CNT_INIT;
            isBranchTaken <= 1'b1;
            branch_pc     <= use_ra ? ex_ra_val : ex_branch_target;
            flush_if      <= 1'b1;
            flush_of      <= 1'b1;
            busy          <= 1'b1;
            if (taken_count != {CNT_W{1'b1}})
              taken_count <= taken_count + CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          if (!stall) begin
            if (cnt == 3'd0) begin
              state    <= ST_IDLE;
              flush_if <= 1'b0;
              flush_of <= 1'b0;
              busy     <= 1'b0;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios plus random traffic on two instances
// (default parameters, and FLUSH_CYCLES=1 / CNT_W=3 to reach saturation quickly).
module tb_branch_resolve;

  localparam logic [4:0] BEQ = 5'b10000, BGT = 5'b10001, BR = 5'b10010,
                         CALL = 5'b10011, RET = 5'b10100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_opcode = '0;
  logic [31:0] tgt = '0;
  logic [31:0] ra = '0;
  logic        gt = 1'b0;
  logic        eq = 1'b0;
  logic        stall = 1'b0;

  logic        tk0, fi0, fo0, bz0;
  logic [31:0] pc0;
  logic [15:0] tc0;
  logic        tk1, fi1, fo1, bz1;
  logic [31:0] pc1;
  logic [2:0]  tc1;

  always #5 clk = ~clk;

  branch_resolve u0 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_branch_target(tgt), .ex_ra_val(ra), .GT_flag(gt), .EQ_flag(eq), .stall(stall),
    .isBranchTaken(tk0), .branch_pc(pc0), .flush_if(fi0), .flush_of(fo0), .busy(bz0),
    .taken_count(tc0)
  );

  branch_resolve #(.DATA_W(32), .FLUSH_CYCLES(1), .CNT_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_branch_target(tgt), .ex_ra_val(ra), .GT_flag(gt), .EQ_flag(eq), .stall(stall),
    .isBranchTaken(tk1), .branch_pc(pc1), .flush_if(fi1), .flush_of(fo1), .busy(bz1),
    .taken_count(tc1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining unstalled squash cycles, pending strobe, last target, count.
  int          fc[2]   = '{2, 1};
  int          maxc[2] = '{65535, 7};
  bit          m_redir[2];
  logic [31:0] m_pc[2];
  int          m_left[2];
  int          m_cnt[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_taken(input logic [4:0] op, input logic g, input logic e);
    case (op)
      BEQ:          return e;
      BGT:          return g;
      BR, CALL, RET: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_redir[i] = 1'b0;
      m_pc[i]    = '0;
      m_left[i]  = 0;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (m_left[i] == 0) begin
        if (ex_valid && !stall && ref_taken(ex_opcode, gt, eq)) begin
          m_redir[i] = 1'b1;
          m_pc[i]    = (ex_opcode == RET) ? ra : tgt;
          m_left[i]  = fc[i];
          if (m_cnt[i] < maxc[i]) m_cnt[i]++;
        end else begin
          m_redir[i] = 1'b0;
        end
      end else begin
        m_redir[i] = 1'b0;
        if (!stall) m_left[i]--;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tk0"}, 64'(tk0), 64'(m_redir[0]));
    chk({tag, ".pc0"}, 64'(pc0), 64'(m_pc[0]));
    chk({tag, ".fi0"}, 64'(fi0), 64'(m_left[0] > 0));
    chk({tag, ".fo0"}, 64'(fo0), 64'(m_left[0] > 0));
    chk({tag, ".bz0"}, 64'(bz0), 64'(m_left[0] > 0));
    chk({tag, ".tc0"}, 64'(tc0), 64'(m_cnt[0]));
    chk({tag, ".tk1"}, 64'(tk1), 64'(m_redir[1]));
    chk({tag, ".pc1"}, 64'(pc1), 64'(m_pc[1]));
    chk({tag, ".fi1"}, 64'(fi1), 64'(m_left[1] > 0));
    chk({tag, ".fo1"}, 64'(fo1), 64'(m_left[1] > 0));
    chk({tag, ".bz1"}, 64'(bz1), 64'(m_left[1] > 0));
    chk({tag, ".tc1"}, 64'(tc1), 64'(m_cnt[1]));
  endtask

  // Called at a negedge: drive inputs, take one clock edge, compare at the next negedge.
  task automatic step(input string tag, input logic v, input logic [4:0] op,
                      input logic [31:0] t, input logic [31:0] r,
                      input logic g, input logic e, input logic s);
    ex_valid = v; ex_opcode = op; tgt = t; ra = r; gt = g; eq = e; stall = s;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  int nflush;
  int nstrobe;

  initial begin
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // beq taken: one strobe, target 0x40, squash for two cycles
    step("t1_res", 1'b1, BEQ, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t1_strobe", 64'(tk0), 64'd1);
    chk("t1_pc", 64'(pc0), 64'h40);
    idle("t1_f2");
    chk("t1_flush_2nd", 64'(fi0), 64'd1);
    idle("t1_f3");
    chk("t1_flush_end", 64'(fi0), 64'd0);
    chk("t1_count", 64'(tc0), 64'd1);

    // bgt not taken
    step("t2", 1'b1, BGT, 32'h80, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t2_no_strobe", 64'(tk0), 64'd0);
    chk("t2_busy", 64'(bz0), 64'd0);

    // ret, then wrong-path b during the flush
    step("t3_res", 1'b1, RET, 32'h99, 32'h1234, 1'b0, 1'b0, 1'b0);
    chk("t3_pc", 64'(pc0), 64'h1234);
    step("t3_wp1", 1'b1, BR, 32'h500, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t3_wp_strobe", 64'(tk0), 64'd0);
    step("t3_wp2", 1'b1, BR, 32'h500, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t3_wp_pc", 64'(pc0), 64'h1234);
    idle("t3_idle");

    // call, then three stalled cycles inside the flush
    step("t4_res", 1'b1, CALL, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
    nflush = int'(fi0);
    nstrobe = int'(tk0);
    for (int k = 0; k < 3; k++) begin
      step("t4_stall", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      nflush += int'(fi0);
      nstrobe += int'(tk0);
    end
    for (int k = 0; k < 4; k++) begin
      idle("t4_run");
      nflush += int'(fi0);
      nstrobe += int'(tk0);
    end
    chk("t4_flush_len", 64'(nflush), 64'd5);
    chk("t4_strobes", 64'(nstrobe), 64'd1);

    // beq held under stall, redirect only once stall drops
    step("t5_s1", 1'b1, BEQ, 32'h300, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t5_s1_strobe", 64'(tk0), 64'd0);
    step("t5_s2", 1'b1, BEQ, 32'h300, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t5_s2_strobe", 64'(tk0), 64'd0);
    step("t5_go", 1'b1, BEQ, 32'h300, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t5_strobe", 64'(tk0), 64'd1);
    chk("t5_pc", 64'(pc0), 64'h300);
    idle("t5_i1");
    idle("t5_i2");

    // asynchronous reset in the middle of a flush
    step("t6_res", 1'b1, BR, 32'h77, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    chk("t6_flush", 64'(fi0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("t6_after");
    idle("t6_after2");

    // saturation: narrow counter must stick at all-ones
    for (int k = 0; k < 10; k++) begin
      step("sat_res", 1'b1, CALL, 32'(k * 4), 32'h0, 1'b0, 1'b0, 1'b0);
      idle("sat_i1");
      idle("sat_i2");
    end
    chk("sat_tc1", 64'(tc1), 64'd7);
    chk("sat_tc0", 64'(tc0), 64'd10);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] op;
      case ($urandom_range(0, 6))
        0: op = BEQ;
        1: op = BGT;
        2: op = BR;
        3: op = CALL;
        4: op = RET;
        default: op = 5'($urandom);
      endcase
      step("rnd", 1'($urandom_range(0, 3) != 0), op, $urandom, $urandom,
           1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
